blit_engine: RTL and testbench

- VRAM block-transfer (blit) unit for the Xosera video core.
- Programmed through XR register writes in the blitter register window (XR 0x40-0x4F, low 4 bits supplied).
- Copies or fills a rectangular 2-D word region of 16-bit VRAM, applying a logic op and nibble write masks.
- Shares VRAM with video gen and the CPU register interface through the VRAM arbiter using a sel/ack handshake; raises a done interrupt per completed blit.

---
 rtl/blit_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_blit_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_engine.sv
// blit_engine: VRAM block-transfer unit. Copies or fills a rectangular region
// of 16-bit words, applying D = (S & ~ANDC) ^ XOR and nibble write masks.
//
// Build option: define BLIT_TRANSP_EN to enable nibble transparency
// (CTRL bit1 / T field). Without it those CTRL bits are ignored.
//
// Ports:
//   clk, reset_n_i              clock, async active-low reset
//   xreg_wr_en_i/num_i/data_i   blitter register writes (shadow set)
//   blit_busy_o, blit_full_o    active-or-queued, queue slot occupied
//   blit_done_intr_o            one-cycle pulse per completed blit
//   blit_vram_sel_o/ack_i       VRAM request / grant handshake
//   blit_wr_o, blit_wr_mask_o   write strobe and nibble enables
//   blit_addr_o, blit_data_o/i  VRAM address and data
//
// state  | meaning
// IDLE   | no active blit
// READ   | source read requested, held until ack
// RDATA  | source word captured from VRAM read data
// WRITE  | destination write requested (skipped when mask is 0)
// NEXT   | advance addresses and word/line down-counters
// DONE   | done pulse; start queued blit if present
module blit_engine (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        xreg_wr_en_i,
  input  logic [3:0]  xreg_num_i,
  input  logic [15:0] xreg_data_i,
  output logic        blit_busy_o,
  output logic        blit_full_o,
  output logic        blit_done_intr_o,
  output logic        blit_vram_sel_o,
  input  logic        blit_vram_ack_i,
  output logic        blit_wr_o,
  output logic [3:0]  blit_wr_mask_o,
  output logic [15:0] blit_addr_o,
  input  logic [15:0] blit_data_i,
  output logic [15:0] blit_data_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_RDATA, ST_WRITE, ST_NEXT, ST_DONE
  } state_t;

  typedef struct packed {
    logic        s_const;
`ifdef BLIT_TRANSP_EN
    logic        transp;
    logic [3:0]  t;
`endif
    logic [15:0] andc;
    logic [15:0] xorv;
    logic [15:0] src;
    logic [15:0] mod_s;
    logic [15:0] dst;
    logic [15:0] mod_d;
    logic [3:0]  m_first;
    logic [3:0]  m_last;
    logic [15:0] lines;
    logic [15:0] words;
  } cfg_t;

  state_t      state_q, state_d;
  cfg_t        sh_q, sh_d;     // shadow registers
  cfg_t        act_q, act_d;   // active blit; src/dst/lines run as counters
  cfg_t        que_q, que_d;   // queued blit snapshot
  logic        q_full_q, q_full_d;
  logic [15:0] wcnt_q, wcnt_d; // words left in current line
  logic [15:0] s_q, s_d;       // current source word

  logic        req;
  logic        first_word, last_word;
  logic [3:0]  word_mask;
  logic [15:0] word_data;
  logic        launch_q, launch_sh, enqueue, idle_like;

  always_comb begin
    sh_d = sh_q;
    req  = 1'b0;
    if (xreg_wr_en_i) begin
      case (xreg_num_i)
        4'd0: begin
          sh_d.s_const = xreg_data_i[0];
`ifdef BLIT_TRANSP_EN
          sh_d.transp  = xreg_data_i[1];
          sh_d.t       = xreg_data_i[11:8];
`endif
        end
        4'd1:  sh_d.andc  = xreg_data_i;
        4'd2:  sh_d.xorv  = xreg_data_i;
        4'd4:  sh_d.src   = xreg_data_i;
        4'd5:  sh_d.mod_s = xreg_data_i;
        4'd6:  sh_d.dst   = xreg_data_i;
        4'd7:  sh_d.mod_d = xreg_data_i;
        4'd8: begin
          sh_d.m_first = xreg_data_i[15:12];
          sh_d.m_last  = xreg_data_i[11:8];
        end
        4'd9:  sh_d.lines = xreg_data_i;
        4'd10: begin
          sh_d.words = xreg_data_i;
          req        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    first_word = (wcnt_q == act_q.words);
    last_word  = (wcnt_q == 16'd0);
    word_mask  = 4'hF;
    if (first_word) word_mask = word_mask & act_q.m_first;
    if (last_word)  word_mask = word_mask & act_q.m_last;
`ifdef BLIT_TRANSP_EN
    if (act_q.transp) begin
      for (int i = 0; i < 4; i++) begin
        if (s_q[4*i +: 4] == act_q.t) word_mask[i] = 1'b0;
      end
    end
`endif
    word_data = (s_q & ~act_q.andc) ^ act_q.xorv;
  end

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    que_d    = que_q;
    q_full_d = q_full_q;
    wcnt_d   = wcnt_q;
    s_d      = s_q;
    blit_vram_sel_o  = 1'b0;
    blit_wr_o        = 1'b0;
    blit_wr_mask_o   = 4'h0;
    blit_addr_o      = 16'h0;
    blit_data_o      = 16'h0;
    blit_done_intr_o = 1'b0;

    // DONE with an empty queue behaves as idle: a new request starts directly.
    idle_like = (state_q == ST_IDLE) || ((state_q == ST_DONE) && !q_full_q);
    launch_q  = (state_q == ST_DONE) && q_full_q;
    launch_sh = req && idle_like;
    enqueue   = req && !idle_like && !q_full_q;

    case (state_q)
      ST_IDLE: ;
      ST_READ: begin
        blit_vram_sel_o = 1'b1;
        blit_addr_o     = act_q.src;
        if (blit_vram_ack_i) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        s_d     = blit_data_i;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (word_mask == 4'h0) begin
          state_d = ST_NEXT;
        end else begin
          blit_vram_sel_o = 1'b1;
          blit_wr_o       = 1'b1;
          blit_addr_o     = act_q.dst;
          blit_data_o     = word_data;
          blit_wr_mask_o  = word_mask;
          if (blit_vram_ack_i) state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (!act_q.s_const) act_d.src = act_q.src + 16'd1;
        act_d.dst = act_q.dst + 16'd1;
        if (last_word) begin
          if (act_q.lines == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            act_d.lines = act_q.lines - 16'd1;
            wcnt_d      = act_q.words;
            if (!act_q.s_const) act_d.src = act_q.src + 16'd1 + act_q.mod_s;
            act_d.dst   = act_q.dst + 16'd1 + act_q.mod_d;
            state_d     = act_q.s_const ? ST_WRITE : ST_READ;
          end
        end else begin
          wcnt_d  = wcnt_q - 16'd1;
          state_d = act_q.s_const ? ST_WRITE : ST_READ;
        end
      end
      ST_DONE: begin
        blit_done_intr_o = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch_q) begin
      act_d    = que_q;
      wcnt_d   = que_q.words;
      s_d      = que_q.src;
      state_d  = que_q.s_const ? ST_WRITE : ST_READ;
      q_full_d = 1'b0;
    end else if (launch_sh) begin
      act_d   = sh_d;
      wcnt_d  = sh_d.words;
      s_d     = sh_d.src;
      state_d = sh_d.s_const ? ST_WRITE : ST_READ;
    end
    if (enqueue) begin
      que_d    = sh_d;
      q_full_d = 1'b1;
    end
  end

  assign blit_busy_o = (state_q != ST_IDLE) || q_full_q;
  assign blit_full_o = q_full_q;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      sh_q     <= '0;
      act_q    <= '0;
      que_q    <= '0;
      q_full_q <= 1'b0;
      wcnt_q   <= 16'd0;
      s_q      <= 16'd0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      act_q    <= act_d;
      que_q    <= que_d;
      q_full_q <= q_full_d;
      wcnt_q   <= wcnt_d;
      s_q      <= s_d;
    end
  end

endmodule

// File: tb/tb_blit_engine.sv
module tb_blit_engine;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        xreg_wr_en_i = 1'b0;
  logic [3:0]  xreg_num_i = 4'h0;
  logic [15:0] xreg_data_i = 16'h0;
  logic        blit_busy_o, blit_full_o, blit_done_intr_o;
  logic        blit_vram_sel_o, blit_wr_o;
  logic        blit_vram_ack_i = 1'b0;
  logic [3:0]  blit_wr_mask_o;
  logic [15:0] blit_addr_o, blit_data_o;
  logic [15:0] blit_data_i = 16'h0;

  blit_engine dut (
    .clk              (clk),
    .reset_n_i        (reset_n_i),
    .xreg_wr_en_i     (xreg_wr_en_i),
    .xreg_num_i       (xreg_num_i),
    .xreg_data_i      (xreg_data_i),
    .blit_busy_o      (blit_busy_o),
    .blit_full_o      (blit_full_o),
    .blit_done_intr_o (blit_done_intr_o),
    .blit_vram_sel_o  (blit_vram_sel_o),
    .blit_vram_ack_i  (blit_vram_ack_i),
    .blit_wr_o        (blit_wr_o),
    .blit_wr_mask_o   (blit_wr_mask_o),
    .blit_addr_o      (blit_addr_o),
    .blit_data_i      (blit_data_i),
    .blit_data_o      (blit_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  mask;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  bit          expect_follow = 1'b0;
  logic [15:0] regs [16];
  logic [15:0] vram [int];
  logic [15:0] mdl [int];

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] vram_rd(input logic [15:0] a);
    if (vram.exists(int'(a))) return vram[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [15:0] mdl_rd(input logic [15:0] a);
    if (mdl.exists(int'(a))) return mdl[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [3:0] m);
    logic [15:0] bm;
    for (int i = 0; i < 4; i++) bm[4*i +: 4] = {4{m[i]}};
    return (old & ~bm) | (d & bm);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference behaviour: the whole rectangle expanded into an ordered list of accesses.
  task automatic model_blit();
    logic [15:0] src, dst, s, d;
    logic [3:0]  m, t;
    bit          sc, tp;
    sc = regs[0][0];
`ifdef BLIT_TRANSP_EN
    tp = regs[0][1];
    t  = regs[0][11:8];
`else
    tp = 1'b0;
    t  = 4'h0;
`endif
    src = regs[4];
    dst = regs[6];
    for (int l = 0; l <= int'(regs[9]); l++) begin
      for (int w = 0; w <= int'(regs[10]); w++) begin
        if (sc) s = regs[4];
        else begin
          s = mdl_rd(src);
          exp_q.push_back('{1'b0, src, 16'h0, 4'h0});
        end
        d = (s & ~regs[1]) ^ regs[2];
        m = 4'hF;
        if (w == 0) m = m & regs[8][15:12];
        if (w == int'(regs[10])) m = m & regs[8][11:8];
        if (tp) for (int i = 0; i < 4; i++) if (s[4*i +: 4] == t) m[i] = 1'b0;
        if (m != 4'h0) begin
          exp_q.push_back('{1'b1, dst, d, m});
          mdl[int'(dst)] = merge(mdl_rd(dst), d, m);
        end
        if (!sc) src = src + 16'd1;
        dst = dst + 16'd1;
      end
      if (!sc) src = src + regs[5];
      dst = dst + regs[7];
    end
    exp_done++;
  endtask

  task automatic wr_reg(input logic [3:0] num, input logic [15:0] data);
    @(negedge clk);
    xreg_wr_en_i = 1'b1;
    xreg_num_i   = num;
    xreg_data_i  = data;
    regs[num]    = data;
    @(posedge clk);
    #1 xreg_wr_en_i = 1'b0;
  endtask

  task automatic start_blit(input logic [15:0] words, input bit accepted);
    wr_reg(4'd10, words);
    if (accepted) model_blit();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (blit_busy_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    check({name, "_busy"}, blit_busy_o, 0);
    check({name, "_full"}, blit_full_o, 0);
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_done_cnt"}, done_cnt, exp_done);
  endtask

  // Arbiter + checker: grants with a 0-3 cycle delay, serves reads, compares every access.
  logic prev_sel = 0, prev_ack = 0, prev_done = 0, rd_pend = 0, ack_now;
  logic [15:0] rd_addr;
  int   wait_cnt = 0, txn_idx = 0;
  txn_t cur, prev_t, e;

  always @(negedge clk) begin
    if (!reset_n_i) begin
      blit_vram_ack_i = 1'b0;
      prev_sel = 0; prev_ack = 0; prev_done = 0; rd_pend = 0; wait_cnt = 0;
    end else begin
      if (rd_pend) begin
        blit_data_i = vram_rd(rd_addr);
        rd_pend = 1'b0;
      end
      cur = '{blit_wr_o, blit_addr_o, blit_data_o, blit_wr_mask_o};
      if (prev_sel && prev_ack) check("sel_gap_after_ack", blit_vram_sel_o, 0);
      else if (prev_sel) begin
        check("req_hold", {blit_vram_sel_o, cur.wr, cur.mask, cur.addr},
              {1'b1, prev_t.wr, prev_t.mask, prev_t.addr});
        if (cur.wr) check("req_hold_data", cur.data, prev_t.data);
      end
      if (prev_done) check("done_width", blit_done_intr_o, 0);
      if (prev_done && expect_follow) begin
        check("queued_start", blit_vram_sel_o, 1);
        expect_follow = 1'b0;
      end
      if (blit_done_intr_o) done_cnt++;
      ack_now = 1'b0;
      if (blit_vram_sel_o) begin
        if (wait_cnt >= (txn_idx % 4)) begin
          ack_now = 1'b1;
          wait_cnt = 0;
          txn_idx++;
        end else wait_cnt++;
      end
      blit_vram_ack_i = ack_now;
      if (blit_vram_sel_o && ack_now) begin
        obs_q.push_back(cur);
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_access: wr %0d addr 0x%0h, none expected", cur.wr, cur.addr);
        end else begin
          e = exp_q.pop_front();
          check("acc_wr", cur.wr, e.wr);
          check("acc_addr", cur.addr, e.addr);
          if (cur.wr) begin
            check("acc_data", cur.data, e.data);
            check("acc_mask", cur.mask, e.mask);
            vram[int'(cur.addr)] = merge(vram_rd(cur.addr), cur.data, cur.mask);
          end else begin
            rd_pend = 1'b1;
            rd_addr = cur.addr;
          end
        end
      end
      prev_sel = blit_vram_sel_o;
      prev_ack = ack_now;
      prev_done = blit_done_intr_o;
      prev_t = cur;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra [4];
    logic [15:0] wa [4];
    bit found;
    foreach (regs[i]) regs[i] = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", blit_busy_o, 0);
    check("rst_full", blit_full_o, 0);
    check("rst_done", blit_done_intr_o, 0);
    check("rst_sel", blit_vram_sel_o, 0);
    check("rst_outs", {blit_wr_o, blit_wr_mask_o, blit_addr_o, blit_data_o}, 0);
    reset_n_i = 1'b1;

    // Fill
    obs_q.delete();
    wr_reg(0, 16'h0001); wr_reg(4, 16'h1234); wr_reg(1, 0); wr_reg(2, 0);
    wr_reg(6, 16'h8000); wr_reg(7, 0); wr_reg(8, 16'hFF00); wr_reg(9, 1);
    start_blit(16'd3, 1);
    check("fill_busy_start", blit_busy_o, 1);
    wait_idle("fill");
    check("fill_count", obs_q.size(), 8);
    for (int i = 0; i < obs_q.size() && i < 8; i++) begin
      check("fill_lit_addr", obs_q[i].addr, 16'h8000 + i);
      check("fill_lit_word", {obs_q[i].wr, obs_q[i].mask, obs_q[i].data}, {1'b1, 4'hF, 16'h1234});
    end

    // Copy
    obs_q.delete();
    ra = '{16'h0100, 16'h0101, 16'h0104, 16'h0105};
    wa = '{16'h0200, 16'h0201, 16'h0206, 16'h0207};
    wr_reg(0, 0); wr_reg(4, 16'h0100); wr_reg(5, 2); wr_reg(6, 16'h0200);
    wr_reg(7, 4); wr_reg(9, 1);
    start_blit(16'd1, 1);
    wait_idle("copy");
    check("copy_count", obs_q.size(), 8);
    for (int i = 0; i < 4 && 2*i+1 < obs_q.size(); i++) begin
      check("copy_lit_raddr", {obs_q[2*i].wr, obs_q[2*i].addr}, {1'b0, ra[i]});
      check("copy_lit_waddr", {obs_q[2*i+1].wr, obs_q[2*i+1].addr}, {1'b1, wa[i]});
      check("copy_lit_data", obs_q[2*i+1].data, init_val(ra[i]));
    end

    // Masks and logic op
    obs_q.delete();
    wr_reg(0, 1); wr_reg(4, 16'hABCD); wr_reg(1, 16'h00FF); wr_reg(2, 16'hF000);
    wr_reg(6, 16'h3000); wr_reg(7, 0); wr_reg(9, 0); wr_reg(8, 16'h8100);
    start_blit(16'd2, 1);
    wait_idle("mask");
    check("mask_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("mask_lit_w0", {obs_q[0].data, obs_q[0].mask}, {16'h5B00, 4'h8});
      check("mask_lit_w1", obs_q[1].mask, 4'hF);
      check("mask_lit_w2", obs_q[2].mask, 4'h1);
    end
    obs_q.delete();
    wr_reg(8, 16'h0F00);
    start_blit(16'd0, 1);
    wait_idle("mask0");
    check("mask0_no_write", obs_q.size(), 0);

    // Queue
    obs_q.delete();
    wr_reg(0, 1); wr_reg(4, 16'h1111); wr_reg(1, 0); wr_reg(2, 0);
    wr_reg(8, 16'hFF00); wr_reg(6, 16'h4000); wr_reg(9, 1);
    start_blit(16'd3, 1);
    wr_reg(4, 16'h2222); wr_reg(6, 16'h5000); wr_reg(9, 0);
    start_blit(16'd1, 1);
    check("q_full_b", blit_full_o, 1);
    check("q_busy_b", blit_busy_o, 1);
    expect_follow = 1'b1;
    wr_reg(4, 16'h3333);
    start_blit(16'd0, 0);
    check("q_full_c", blit_full_o, 1);
    wait_idle("queue");
    check("q_follow_seen", expect_follow, 0);
    check("q_count", obs_q.size(), 10);
    if (obs_q.size() == 10) check("q_lit_b", {obs_q[8].addr, obs_q[8].data}, {16'h5000, 16'h2222});

    // Transparency
    obs_q.delete();
    wr_reg(0, 16'h0003); wr_reg(4, 16'h0A0B); wr_reg(6, 16'h6000); wr_reg(8, 16'hFF00);
    start_blit(16'd0, 1);
    wait_idle("transp");
    check("transp_count", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
`ifdef BLIT_TRANSP_EN
      check("transp_lit_mask", obs_q[0].mask, 4'b0101);
`else
      check("transp_lit_mask", obs_q[0].mask, 4'hF);
`endif
    end

    // Reset mid-write
    wr_reg(0, 1); wr_reg(4, 16'h9999); wr_reg(6, 16'h7000); wr_reg(9, 3);
    start_blit(16'd7, 1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (blit_vram_sel_o && blit_wr_o) found = 1'b1;
    end
    check("rst_found_write", found, 1);
    #2 reset_n_i = 1'b0;
    blit_vram_ack_i = 1'b0;
    #1;
    check("rst_mid_sel", blit_vram_sel_o, 0);
    check("rst_mid_busy", blit_busy_o, 0);
    check("rst_mid_full", blit_full_o, 0);
    check("rst_mid_done", blit_done_intr_o, 0);
    exp_q.delete(); obs_q.delete(); vram.delete(); mdl.delete();
    foreach (regs[i]) regs[i] = 16'h0;
    done_cnt = 0; exp_done = 0;
    repeat (3) @(negedge clk);
    reset_n_i = 1'b1;
    repeat (4) @(negedge clk);
    wr_reg(0, 1); wr_reg(4, 16'h7777); wr_reg(6, 16'h0040); wr_reg(8, 16'hFF00);
    start_blit(16'd1, 1);
    wait_idle("post_rst");
    check("post_rst_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      check("post_rst_lit0", {obs_q[0].addr, obs_q[0].data}, {16'h0040, 16'h7777});
      check("post_rst_lit1", obs_q[1].addr, 16'h0041);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
